if_stage: RTL and testbench

Instruction fetch stage of the RISC-V CPU. Holds the program counter, drives the combinational instruction-memory port, and buffers fetched words in a small queue. It presents them in order to the decode stage over a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch. A misaligned redirect target is marked as an exception and fetch stops.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/if_stage_if.sv | 45 ++++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg : types and constants shared by the instruction fetch stage
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP, misalign: 1'b0};

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_TRAP = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if : instruction-memory, redirect and decode handshake signals
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface if_stage_if;

  logic [31:0] instr_addr_o;
  logic [31:0] instr_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_misalign_o;

  modport master (
    output instr_addr_o,
    input  instr_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    output id_valid_o,
    input  id_ready_i,
    output id_pc_o,
    output id_instr_o,
    output id_misalign_o
  );

  modport slave (
    input  instr_addr_o,
    output instr_data_i,
    output redirect_i,
    output redirect_pc_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_pc_o,
    input  id_instr_o,
    input  id_misalign_o
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue : power-of-two FIFO of fetched entries with synchronous flush
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push,
  input  wire fetch_entry_t push_entry,
  input  wire logic         pop,
  input  wire logic         flush,
  output logic              full,
  output logic              empty,
  output fetch_entry_t      head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  fetch_entry_t     mem [DEPTH];

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= EMPTY_ENTRY;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : fetch PC, fetch state machine and decode-side fetch queue
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  if_stage_if.master  bus
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign bus.instr_addr_o = pc_q;

  // A redirect discards any handshake in the same cycle.
  assign pop = !empty && bus.id_ready_i && !bus.redirect_i;

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    push       = 1'b0;
    push_entry = '{pc: pc_q, instr: bus.instr_data_i, misalign: 1'b0};
    if (bus.redirect_i) begin
      state_next = FETCH_RUN;
      pc_next    = bus.redirect_pc_i;
    end else if (state == FETCH_RUN && (!full || pop)) begin
      push = 1'b1;
      if (pc_q[1:0] != 2'b00) begin
        push_entry.instr    = NOP;
        push_entry.misalign = 1'b1;
        state_next          = FETCH_TRAP;
      end else begin
        pc_next = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_RUN;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_i),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  assign bus.id_valid_o    = !empty;
  assign bus.id_pc_o       = head.pc;
  assign bus.id_instr_o    = head.instr;
  assign bus.id_misalign_o = head.misalign;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : scoreboard bench for if_stage, directed cases then random mix
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected in-order stream of entries decode should see since the last restart.
  fetch_entry_t exp_q[$];

  if_stage_if bus ();

  if_stage #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.instr_data_i = mem_word(bus.instr_addr_o);

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Fetch restarts at start: sequential words, or one trap entry if misaligned.
  task automatic expect_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    if (start[1:0] != 2'b00) begin
      exp_q.push_back('{pc: start, instr: NOP, misalign: 1'b1});
    end else begin
      for (int k = 0; k < 512; k++) begin
        a = start + 32'(k) * 32'd4;
        exp_q.push_back('{pc: a, instr: mem_word(a), misalign: 1'b0});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = t;
    expect_stream(t);
    step();
    bus.redirect_i = 1'b0;
    check("redirect_valid_low", bus.id_valid_o, 0);
    check("redirect_addr", bus.instr_addr_o, t);
  endtask

  always @(negedge clk) begin
    if (!rst && !bus.redirect_i && bus.id_valid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_entry: actual pc %0h instr %0h required no entry",
                 bus.id_pc_o, bus.id_instr_o);
      end else begin
        check("head_entry", {bus.id_pc_o, bus.id_instr_o, bus.id_misalign_o},
              {exp_q[0].pc, exp_q[0].instr, exp_q[0].misalign});
        if (bus.id_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i    = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_valid", bus.id_valid_o, 0);
    check("reset_addr", bus.instr_addr_o, RESET_PC);
    check("reset_pc", bus.id_pc_o, 0);
    check("reset_instr", bus.id_instr_o, NOP);
    check("reset_misalign", bus.id_misalign_o, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_stream(RESET_PC);
    bus.id_ready_i = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      check("stream_valid", bus.id_valid_o, 1);
      check("stream_pc", bus.id_pc_o, 32'(i) * 32'd4);
      check("stream_addr", bus.instr_addr_o, 32'(i + 1) * 32'd4);
    end

    bus.id_ready_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("stall_head", bus.id_pc_o, 32'h8);
      check("stall_addr", bus.instr_addr_o, 32'h10);
    end
    bus.id_ready_i = 1'b1;
    step();
    check("drain_pc1", bus.id_pc_o, 32'hC);
    step();
    check("drain_pc2", bus.id_pc_o, 32'h10);

    bus.id_ready_i = 1'b0;
    step();
    step();
    redirect_to(32'h100);
    bus.id_ready_i = 1'b1;
    step();
    check("redir_head_valid", bus.id_valid_o, 1);
    check("redir_head_pc", bus.id_pc_o, 32'h100);
    step();
    check("redir_next_pc", bus.id_pc_o, 32'h104);

    redirect_to(32'h102);
    step();
    check("trap_entry", {bus.id_valid_o, bus.id_pc_o, bus.id_instr_o, bus.id_misalign_o},
          {1'b1, 32'h102, NOP, 1'b1});
    for (int j = 0; j < 10; j++) begin
      step();
      check("trap_quiet_valid", bus.id_valid_o, 0);
      check("trap_addr", bus.instr_addr_o, 32'h102);
    end
    redirect_to(32'h20);
    step();
    check("resume_entry", {bus.id_pc_o, bus.id_misalign_o}, {32'h20, 1'b0});

    redirect_to(32'hFFFF_FFFC);
    step();
    check("wrap_pc0", bus.id_pc_o, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", bus.id_pc_o, 32'h0);
    step();
    check("wrap_pc2", bus.id_pc_o, 32'h4);

    repeat (3) step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_valid", bus.id_valid_o, 0);
    check("async_rst_addr", bus.instr_addr_o, RESET_PC);
    check("async_rst_instr", bus.id_instr_o, NOP);
    step();
    rst = 1'b0;
    expect_stream(RESET_PC);
    step();
    check("restart_pc0", {bus.id_valid_o, bus.id_pc_o}, {1'b1, RESET_PC});
    step();
    check("restart_pc1", bus.id_pc_o, RESET_PC + 32'd4);

    for (int c = 0; c < 300; c++) begin
      bus.id_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(2))
          0:       t = $urandom & 32'h0000_0FFC;
          1:       t = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
          default: t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
        endcase
        redirect_to(t);
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
